// File: rtl/reg_check_monitor_pkg.sv
// Shared types and width helpers for the register self-check monitor.
package rcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CHECKS_DEF = 8;
    localparam int IDX_W = idx_w(NUM_CHECKS_DEF);
    localparam int CNT_W = $clog2(NUM_CHECKS_DEF + 1);

endpackage

// File: rtl/reg_check_monitor_shadow_regfile.sv
// Shadow copy of the core register file: one write port, one async read port.
module shadow_regfile #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_HW = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              zero_wr;

    assign zero_wr = (ZERO_HW != 0) && (waddr == '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !zero_wr) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 reads as zero even if the array slot were ever disturbed
    assign rdata = ((ZERO_HW != 0) && (raddr == '0)) ? '0 : regs[raddr];

endmodule

// File: rtl/reg_check_monitor.sv
// Snoops core register writes, then compares the shadow copy against
// a loaded table of expected values once the program halts or times out.
module reg_check_monitor
    import rcm_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RADDR_W    = 3,
    parameter int NUM_CHECKS = 8,
    parameter int CYC_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int ZERO_HW    = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                halt,
    input  logic                                wr_en,
    input  logic [RADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    input  logic                                exp_we,
    input  logic [idx_w(NUM_CHECKS)-1:0]        exp_idx,
    input  logic [RADDR_W-1:0]                  exp_addr,
    input  logic [DATA_W-1:0]                   exp_data,
    input  logic                                exp_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic                                timed_out,
    output logic [idx_w(NUM_CHECKS)-1:0]        first_fail,
    output logic [$clog2(NUM_CHECKS+1)-1:0]     mism_count,
    output logic [CYC_W-1:0]                    cycle_count
);

    localparam int IW = idx_w(NUM_CHECKS);
    localparam int CW = $clog2(NUM_CHECKS + 1);
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_CHECKS - 1);

    state_t state;
    state_t state_nx;

    logic               tab_valid [NUM_CHECKS];
    logic [RADDR_W-1:0] tab_addr  [NUM_CHECKS];
    logic [DATA_W-1:0]  tab_data  [NUM_CHECKS];

    logic [IW-1:0]      chk_idx;
    logic               idle_like;
    logic               go;
    logic               tab_wr;
    logic               at_limit;
    logic               shadow_clr;
    logic               shadow_we;
    logic [RADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               entry_fail;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign go         = idle_like && start;
    assign tab_wr     = idle_like && exp_we;
    assign at_limit   = (cycle_count == TO_LAST);
    assign shadow_clr = reset || go;
    assign shadow_we  = (state == RUN) && wr_en;

    assign rd_addr    = tab_addr[chk_idx];
    assign entry_fail = tab_valid[chk_idx] && (rd_data != tab_data[chk_idx]);

    shadow_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (RADDR_W),
        .ZERO_HW (ZERO_HW)
    ) u_shadow (
        .clock (clock),
        .clear (shadow_clr),
        .we    (shadow_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        pass     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (halt || at_limit) state_nx = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (chk_idx == LAST_IDX) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (mism_count == '0) && !timed_out;
                if (start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            chk_idx     <= '0;
            cycle_count <= '0;
            mism_count  <= '0;
            first_fail  <= '0;
            timed_out   <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                chk_idx     <= '0;
                cycle_count <= '0;
                mism_count  <= '0;
                first_fail  <= '0;
                timed_out   <= 1'b0;
            end
            if (state == RUN) begin
                chk_idx <= '0;
                if (cycle_count != CYC_MAX) begin
                    cycle_count <= cycle_count + CYC_W'(1);
                end
                // halt in the limit cycle counts as a normal end
                if (!halt && at_limit) begin
                    timed_out <= 1'b1;
                end
            end
            if (state == CHECK) begin
                chk_idx <= chk_idx + IW'(1);
                if (entry_fail) begin
                    mism_count <= mism_count + CW'(1);
                    if (mism_count == '0) begin
                        first_fail <= chk_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tab_valid[i] <= 1'b0;
                tab_addr[i]  <= '0;
                tab_data[i]  <= '0;
            end
        end else if (tab_wr && (int'(exp_idx) < NUM_CHECKS)) begin
            tab_valid[exp_idx] <= exp_valid;
            tab_addr[exp_idx]  <= exp_addr;
            tab_data[exp_idx]  <= exp_data;
        end
    end

endmodule

// File: tb/tb_reg_check_monitor.sv
// Self-checking bench for reg_check_monitor: directed vectors, corner
// sequences and a randomized run against a register-level model.
module tb_reg_check_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_valid;

    logic        busy, done, pass, timed_out;
    logic [2:0]  first_fail;
    logic [3:0]  mism_count;
    logic [15:0] cycle_count;

    logic        busy_z, done_z, pass_z, timed_out_z;
    logic [2:0]  first_fail_z;
    logic [3:0]  mism_count_z;
    logic [15:0] cycle_count_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    reg_check_monitor dut (
        .clock(clock), .reset(reset), .start(start), .halt(halt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_valid(exp_valid),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .first_fail(first_fail), .mism_count(mism_count),
        .cycle_count(cycle_count)
    );

    reg_check_monitor #(.ZERO_HW(0)) dut_z (
        .clock(clock), .reset(reset), .start(start), .halt(halt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_valid(exp_valid),
        .busy(busy_z), .done(done_z), .pass(pass_z),
        .timed_out(timed_out_z), .first_fail(first_fail_z),
        .mism_count(mism_count_z), .cycle_count(cycle_count_z)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; halt = 0; wr_en = 0;
        wr_addr = 0; wr_data = 0; exp_we = 0; exp_idx = 0;
        exp_addr = 0; exp_data = 0; exp_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic load(input int idx, input int a, input int d,
                        input logic v);
        exp_we = 1; exp_idx = 3'(idx); exp_addr = 3'(a);
        exp_data = 16'(d); exp_valid = v;
        tick();
        exp_we = 0; exp_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic cyc(input logic en, input int a, input int d,
                       input logic h);
        wr_en = en; wr_addr = 3'(a); wr_data = 16'(d); halt = h;
        tick();
        wr_en = 0; halt = 0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int k = 0;
        while (!done && k < max) begin
            tick();
            k++;
        end
        chk(nm, done, 1);
    endtask

    typedef struct {
        int         eaddr;
        int         edata;
        int         waddr;
        int         wdata;
        logic       pass_e;
        logic [3:0] mism_e;
    } vec_t;

    vec_t vecs [6];

    int m_reg   [8];
    bit m_valid [8];
    int m_addr  [8];
    int m_data  [8];

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tmo", timed_out, 0);
        chk("rst_ff", first_fail, 0);
        chk("rst_mism", mism_count, 0);
        chk("rst_cyc", cycle_count, 0);

        // test 1: two matching entries, halt at cycle 6
        load(0, 3, 16'h0004, 1);
        load(1, 4, 16'h0001, 1);
        pulse_start();
        chk("t1_busy", busy, 1);
        cyc(1, 3, 16'h0004, 0);
        cyc(1, 4, 16'h0001, 0);
        for (int i = 2; i < 6; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) tick();
        chk("t1_check_len", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_mism", mism_count, 0);
        chk("t1_cyc", cycle_count, 7);

        // test 2: r4 wrong
        do_reset();
        load(0, 3, 16'h0004, 1);
        load(1, 4, 16'h0001, 1);
        pulse_start();
        cyc(1, 3, 16'h0004, 0);
        cyc(1, 4, 16'h0003, 0);
        for (int i = 2; i < 6; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        wait_done("t2_done", 20);
        chk("t2_pass", pass, 0);
        chk("t2_mism", mism_count, 1);
        chk("t2_ff", first_fail, 1);

        // test 3: write to r0 under both ZERO_HW settings
        do_reset();
        load(0, 0, 16'h0000, 1);
        pulse_start();
        cyc(1, 0, 16'hFFFF, 0);
        cyc(0, 0, 0, 1);
        wait_done("t3_done", 20);
        chk("t3_pass_hw", pass, 1);
        chk("t3_pass_nohw", pass_z, 0);
        chk("t3_mism_nohw", mism_count_z, 1);

        // test 4: timeout with matching table
        do_reset();
        load(0, 1, 16'h0000, 1);
        pulse_start();
        wait_done("t4_done", 1100);
        chk("t4_tmo", timed_out, 1);
        chk("t4_cyc", cycle_count, 1000);
        chk("t4_pass", pass, 0);
        chk("t4_mism", mism_count, 0);

        // test 4b: halt coincides with the timeout cycle
        do_reset();
        pulse_start();
        for (int i = 0; i < 999; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        wait_done("t4b_done", 20);
        chk("t4b_tmo", timed_out, 0);
        chk("t4b_cyc", cycle_count, 1000);
        chk("t4b_pass", pass, 1);

        // test 5: reset in the middle of CHECK
        do_reset();
        load(0, 2, 16'h0005, 1);
        pulse_start();
        cyc(1, 2, 16'h0001, 1);
        tick();
        tick();
        chk("t5_mid_busy", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_cyc", cycle_count, 0);
        pulse_start();
        cyc(0, 0, 0, 1);
        wait_done("t5_done2", 20);
        chk("t5_pass", pass, 1);

        // test 6: table write and start ignored during RUN
        do_reset();
        load(0, 5, 16'h1234, 1);
        pulse_start();
        exp_we = 1; exp_idx = 0; exp_addr = 3'd5;
        exp_data = 16'hBEEF; exp_valid = 1; start = 1;
        tick();
        exp_we = 0; start = 0; exp_valid = 0;
        chk("t6_busy", busy, 1);
        cyc(1, 5, 16'h1234, 1);
        wait_done("t6_done", 20);
        chk("t6_pass", pass, 1);
        chk("t6_cyc", cycle_count, 2);

        // test 6b: start and exp_we together in IDLE
        do_reset();
        exp_we = 1; exp_idx = 3'd7; exp_addr = 3'd6;
        exp_data = 16'h00AA; exp_valid = 1; start = 1;
        tick();
        exp_we = 0; start = 0; exp_valid = 0;
        chk("t6b_busy", busy, 1);
        cyc(0, 0, 0, 1);
        wait_done("t6b_done", 20);
        chk("t6b_mism", mism_count, 1);
        chk("t6b_ff", first_fail, 7);

        // single-entry vectors, write captured in the halt cycle
        vecs[0] = '{7, 16'hFFFF, 7, 16'hFFFF, 1'b1, 4'd0};
        vecs[1] = '{7, 16'hFFFF, 6, 16'hFFFF, 1'b0, 4'd1};
        vecs[2] = '{0, 16'h0000, 0, 16'h1234, 1'b1, 4'd0};
        vecs[3] = '{1, 16'h8000, 1, 16'h8001, 1'b0, 4'd1};
        vecs[4] = '{2, 16'h0000, 3, 16'h0005, 1'b1, 4'd0};
        vecs[5] = '{6, 16'h0001, 6, 16'h0001, 1'b1, 4'd0};
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load(3, vecs[v].eaddr, vecs[v].edata, 1);
            pulse_start();
            cyc(1, vecs[v].waddr, vecs[v].wdata, 1);
            wait_done($sformatf("vec%0d_done", v), 20);
            chk($sformatf("vec%0d_pass", v), pass, vecs[v].pass_e);
            chk($sformatf("vec%0d_mism", v), mism_count, vecs[v].mism_e);
            chk($sformatf("vec%0d_cyc", v), cycle_count, 1);
        end

        // randomized runs against a register-level model
        do_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        for (int it = 0; it < 25; it++) begin
            int len;
            int em;
            int eff;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    m_valid[i] = ($urandom_range(0, 3) != 0);
                    m_addr[i]  = $urandom_range(0, 7);
                    m_data[i]  = $urandom_range(0, 3);
                    load(i, m_addr[i], m_data[i], m_valid[i]);
                end
            end
            for (int r = 0; r < 8; r++) m_reg[r] = 0;
            len = $urandom_range(1, 20);
            pulse_start();
            for (int c = 0; c < len; c++) begin
                logic en;
                int a;
                int d;
                en = 1'($urandom_range(0, 1));
                a  = $urandom_range(0, 7);
                d  = $urandom_range(0, 3);
                if (en && a != 0) m_reg[a] = d;
                cyc(en, a, d, (c == len - 1));
            end
            em = 0;
            eff = 0;
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i] && m_reg[m_addr[i]] != m_data[i]) begin
                    if (em == 0) eff = i;
                    em++;
                end
            end
            wait_done($sformatf("rnd%0d_done", it), 20);
            chk($sformatf("rnd%0d_mism", it), mism_count, em);
            chk($sformatf("rnd%0d_ff", it), first_fail, eff);
            chk($sformatf("rnd%0d_pass", it), pass, (em == 0));
            chk($sformatf("rnd%0d_cyc", it), cycle_count, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
